axi_lite_data_sram: RTL and testbench

- Data-side AXI-lite slave memory directly downstream of the load/store unit.
- Serves its read channel (ar/r) and write channel (aw/w/b) with per-byte strobes.
- Read and write latency are configurable, so the LSU handshake FSMs are exercised under both immediate and delayed responses.
- Channel widths and the 3-bit response encoding match the LSU master side exactly.

---
 rtl/axi_lite_data_sram.sv | 198 +++++++++++++++++++
 tb/tb_axi_lite_data_sram.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_data_sram.sv
// axi_lite_data_sram: AXI-lite data-side slave memory for the LSU with per-byte strobes
// and configurable read/write response latency.
module axi_lite_data_sram #(
   parameter int                  DATA_LEN       = 32,
   parameter int                  DATA_BIT_NUM   = 4,
   parameter int                  MEM_DEPTH_LOG2 = 12,
   parameter logic [DATA_LEN-1:0] BASE_ADDR      = 32'h8000_0000,
   parameter int                  READ_LATENCY   = 1,
   parameter int                  WRITE_LATENCY  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_LEN-1:0]     waddr,
   input  logic                    wvalid,
   output logic                    wready,
   input  logic [DATA_BIT_NUM-1:0] wstrob,
   input  logic [DATA_LEN-1:0]     wdata,
   output logic                    bvalid,
   input  logic                    bready,
   output logic [2:0]              bresp,
   input  logic                    arvalid,
   output logic                    arready,
   input  logic [DATA_LEN-1:0]     raddr,
   output logic                    rvalid,
   input  logic                    rready,
   output logic [2:0]              rresp,
   output logic [DATA_LEN-1:0]     rdata
);
   localparam int                  CW     = 16;
   localparam logic [DATA_LEN-1:0] WIN    = DATA_LEN'(64'd4 << MEM_DEPTH_LOG2);
   localparam logic [2:0]          OKAY   = 3'b000;
   localparam logic [2:0]          SLVERR = 3'b010;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
   typedef enum logic [1:0] {W_IDLE, W_DELAY, W_RESP} w_state_e;

   logic [DATA_LEN-1:0] mem [2**MEM_DEPTH_LOG2];

   r_state_e                r_state_q, r_state_d;
   logic [DATA_LEN-1:0]     raddr_q, raddr_d;
   logic [CW-1:0]           rcnt_q, rcnt_d;
   logic                    arready_q, arready_d;
   logic                    rvalid_q, rvalid_d;
   logic [2:0]              rresp_q, rresp_d;
   logic [DATA_LEN-1:0]     rdata_q, rdata_d;

   w_state_e                w_state_q, w_state_d;
   logic [DATA_LEN-1:0]     waddr_q, waddr_d;
   logic [DATA_LEN-1:0]     wdata_q, wdata_d;
   logic [DATA_BIT_NUM-1:0] wstrb_q, wstrb_d;
   logic [CW-1:0]           wcnt_q, wcnt_d;
   logic                    awready_q, awready_d;
   logic                    wready_q, wready_d;
   logic                    bvalid_q, bvalid_d;
   logic [2:0]              bresp_q, bresp_d;
   logic                    w_commit;
   logic                    mem_we;

   function automatic logic in_win(input logic [DATA_LEN-1:0] a);
      return a >= BASE_ADDR && a - BASE_ADDR < WIN;
   endfunction

   // Every read passes through R_WAIT so rvalid lands READ_LATENCY edges after ar.
   always_comb begin
      r_state_d = r_state_q;
      raddr_d   = raddr_q;
      rcnt_d    = rcnt_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      case (r_state_q)
         R_IDLE: if (arvalid) begin
            raddr_d   = raddr;
            rcnt_d    = CW'(READ_LATENCY - 1);
            arready_d = 1'b0;
            r_state_d = R_WAIT;
         end
         R_WAIT: begin
            rcnt_d = rcnt_q - CW'(1);
            if (rcnt_q == '0) begin
               rvalid_d  = 1'b1;
               rresp_d   = in_win(raddr_q) ? OKAY : SLVERR;
               rdata_d   = in_win(raddr_q) ? mem[raddr_q[MEM_DEPTH_LOG2+1:2]] : '0;
               r_state_d = R_RESP;
            end
         end
         R_RESP: if (rready) begin
            rvalid_d  = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // aw and w are captured independently; the ready flags double as "not yet captured".
   always_comb begin
      w_state_d = w_state_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      wcnt_d    = wcnt_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      w_commit  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (awvalid && awready_q) begin
               waddr_d   = waddr;
               awready_d = 1'b0;
            end
            if (wvalid && wready_q) begin
               wdata_d  = wdata;
               wstrb_d  = wstrob;
               wready_d = 1'b0;
            end
            if (!awready_d && !wready_d) begin
               wcnt_d    = CW'(WRITE_LATENCY - 1);
               w_state_d = W_DELAY;
            end
         end
         W_DELAY: begin
            wcnt_d = wcnt_q - CW'(1);
            if (wcnt_q == '0) begin
               w_commit  = 1'b1;
               bvalid_d  = 1'b1;
               bresp_d   = in_win(waddr_q) ? OKAY : SLVERR;
               w_state_d = W_RESP;
            end
         end
         W_RESP: if (bready) begin
            bvalid_d  = 1'b0;
            awready_d = 1'b1;
            wready_d  = 1'b1;
            w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   assign mem_we = w_commit && in_win(waddr_q);

   always_ff @(posedge clk)
      if (mem_we)
         for (int i = 0; i < DATA_BIT_NUM; i++)
            if (wstrb_q[i]) mem[waddr_q[MEM_DEPTH_LOG2+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state_q <= R_IDLE;
         raddr_q   <= '0;
         rcnt_q    <= '0;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rresp_q   <= '0;
         rdata_q   <= '0;
         w_state_q <= W_IDLE;
         waddr_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         wcnt_q    <= '0;
         awready_q <= 1'b1;
         wready_q  <= 1'b1;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         raddr_q   <= raddr_d;
         rcnt_q    <= rcnt_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         w_state_q <= w_state_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         wcnt_q    <= wcnt_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end

   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rresp   = rresp_q;
   assign rdata   = rdata_q;
   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
endmodule

// File: tb/tb_axi_lite_data_sram.sv
// tb_axi_lite_data_sram: scoreboard bench for two memory instances, one with unit
// latencies and one with read latency 3 / write latency 4.
module tb_axi_lite_data_sram;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0] awvalid, awready, wvalid, wready, bvalid, bready;
   logic [1:0] arvalid, arready, rvalid, rready;
   logic [1:0][31:0] waddr, wdata, raddr, rdata;
   logic [1:0][3:0] wstrob;
   logic [1:0][2:0] bresp, rresp;

   int n_chk = 0;
   int n_fail = 0;
   logic [34:0] rq[$];
   logic [2:0] bq[$];
   logic [31:0] mdl[int];
   logic [34:0] me;
   logic [2:0] mb;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      axi_lite_data_sram #(
         .READ_LATENCY (g == 1 ? 3 : 1),
         .WRITE_LATENCY(g == 1 ? 4 : 1)
      ) dut (
         .clk(clk), .rst_n(rst_n),
         .awvalid(awvalid[g]), .awready(awready[g]), .waddr(waddr[g]),
         .wvalid(wvalid[g]), .wready(wready[g]), .wstrob(wstrob[g]), .wdata(wdata[g]),
         .bvalid(bvalid[g]), .bready(bready[g]), .bresp(bresp[g]),
         .arvalid(arvalid[g]), .arready(arready[g]), .raddr(raddr[g]),
         .rvalid(rvalid[g]), .rready(rready[g]), .rresp(rresp[g]), .rdata(rdata[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic in_win(input logic [31:0] a);
      return a >= 32'h8000_0000 && a < 32'h8000_4000;
   endfunction

   function automatic int key(input int u, input logic [31:0] a);
      return u * 65536 + int'(a[13:2]);
   endfunction

   task automatic mwrite(input int u, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] v;
      if (in_win(a)) begin
         v = mdl.exists(key(u, a)) ? mdl[key(u, a)] : 32'h0;
         for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
         mdl[key(u, a)] = v;
      end
      bq.push_back(in_win(a) ? 3'b000 : 3'b010);
   endtask

   task automatic wr(input int u, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int lat, input int gap, input int stall);
      int c;
      logic [2:0] eb;
      @(negedge clk);
      check("aw_rdy", 32'({awready[u], wready[u]}), 32'b11);
      eb = in_win(a) ? 3'b000 : 3'b010;
      waddr[u] = a; wdata[u] = d; wstrob[u] = s; wvalid[u] = 1'b1;
      bready[u] = (stall == 0);
      if (gap == 0) awvalid[u] = 1'b1;
      else begin
         @(posedge clk); #1 wvalid[u] = 1'b0;
         @(negedge clk);
         check("w_only", 32'({awready[u], wready[u]}), 32'b10);
         repeat (gap - 1) @(negedge clk);
         awvalid[u] = 1'b1;
      end
      @(posedge clk); #1 awvalid[u] = 1'b0; wvalid[u] = 1'b0;
      mwrite(u, a, d, s);
      c = 0;
      do begin @(posedge clk); c++; @(negedge clk); end while (!bvalid[u] && c < 20);
      check("b_lat", c, lat);
      repeat (stall) begin
         @(posedge clk); @(negedge clk);
         check("b_hold", 32'({bvalid[u], bresp[u]}), 32'({1'b1, eb}));
         check("aw_low", 32'({awready[u], wready[u]}), 32'b00);
      end
      if (stall > 0) begin @(posedge clk); #1 bready[u] = 1'b1; @(negedge clk); end
      @(posedge clk); @(negedge clk);
      check("b_done", 32'({bvalid[u], awready[u], wready[u]}), 32'b011);
   endtask

   task automatic rd(input int u, input logic [31:0] a, input int lat, input int stall);
      int c;
      logic [34:0] e;
      @(negedge clk);
      check("ar_rdy", 32'(arready[u]), 32'd1);
      e = in_win(a) ? {3'b000, mdl[key(u, a)]} : {3'b010, 32'h0};
      rq.push_back(e);
      raddr[u] = a; arvalid[u] = 1'b1; rready[u] = (stall == 0);
      @(posedge clk); #1 arvalid[u] = 1'b0;
      c = 0;
      do begin @(posedge clk); c++; @(negedge clk); end while (!rvalid[u] && c < 20);
      check("r_lat", c, lat);
      repeat (stall) begin
         @(posedge clk); @(negedge clk);
         check("r_hold", rdata[u], e[31:0]);
         check("r_hold_v", 32'({rvalid[u], rresp[u]}), 32'({1'b1, e[34:32]}));
         check("ar_low", 32'(arready[u]), 32'd0);
      end
      if (stall > 0) begin @(posedge clk); #1 rready[u] = 1'b1; @(negedge clk); end
      @(posedge clk); @(negedge clk);
      check("r_done", 32'({rvalid[u], arready[u]}), 32'b01);
   endtask

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (rvalid[u] && rready[u]) begin
            check("rq_depth", rq.size(), 1);
            if (rq.size() > 0) begin
               me = rq.pop_front();
               check("rdata", rdata[u], me[31:0]);
               check("rresp", 32'(rresp[u]), 32'(me[34:32]));
            end
         end
         if (bvalid[u] && bready[u]) begin
            check("bq_depth", bq.size(), 1);
            if (bq.size() > 0) begin
               mb = bq.pop_front();
               check("bresp", 32'(bresp[u]), 32'(mb));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, d;
      logic [3:0] s;
      awvalid = '0; wvalid = '0; arvalid = '0; bready = '1; rready = '1;
      waddr = '0; wdata = '0; raddr = '0; wstrob = '0;
      repeat (2) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         check("rst_ctl", 32'({arready[u], awready[u], wready[u], rvalid[u], bvalid[u]}), 32'b11100);
         check("rst_resp", 32'({rresp[u], bresp[u]}), 32'd0);
         check("rst_rdata", rdata[u], 32'd0);
      end
      rst_n = 1'b1;

      wr(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1, 0, 0);
      rd(0, 32'h8000_0010, 1, 0);
      wr(0, 32'h8000_0010, 32'h0000_0055, 4'b0001, 1, 0, 0);
      wr(0, 32'h8000_0010, 32'hAAAA_0000, 4'b1100, 1, 0, 0);
      rd(0, 32'h8000_0012, 1, 0);
      wr(0, 32'h8000_0010, 32'h1234_5678, 4'b0000, 1, 0, 0);
      rd(0, 32'h8000_0010, 1, 0);

      wr(1, 32'h8000_0020, 32'h1234_5678, 4'hF, 4, 3, 0);
      rd(1, 32'h8000_0020, 3, 0);

      wr(0, 32'h8000_0030, 32'h0BAD_F00D, 4'hF, 1, 0, 5);
      rd(0, 32'h8000_0030, 1, 5);
      wr(1, 32'h8000_0034, 32'h5A5A_A5A5, 4'hF, 4, 0, 5);
      rd(1, 32'h8000_0034, 3, 5);

      wr(0, 32'h8000_1000, 32'h1111_1111, 4'hF, 1, 0, 0);
      wr(0, 32'h8000_0000, 32'h2222_2222, 4'hF, 1, 0, 0);
      wr(0, 32'h8000_3FFC, 32'h3333_3333, 4'hF, 1, 0, 0);
      rd(0, 32'h0000_1000, 1, 0);
      rd(0, 32'h8000_4000, 1, 0);
      rd(0, 32'h7FFF_FFFC, 1, 0);
      wr(0, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 1, 0, 0);
      wr(0, 32'h8000_4000, 32'hEEEE_EEEE, 4'hF, 1, 0, 0);
      rd(0, 32'h8000_1000, 1, 0);
      rd(0, 32'h8000_0000, 1, 0);
      rd(0, 32'h8000_3FFC, 1, 0);
      rd(0, 32'h8000_0010, 1, 0);

      wr(0, 32'h8000_0040, 32'h0000_0000, 4'hF, 1, 0, 0);
      fork
         rd(0, 32'h8000_0040, 1, 0);
         wr(0, 32'h8000_0040, 32'hCAFE_F00D, 4'hF, 1, 0, 0);
      join
      rd(0, 32'h8000_0040, 1, 0);

      @(negedge clk);
      raddr[1] = 32'h8000_0020; arvalid[1] = 1'b1;
      @(posedge clk); #1 arvalid[1] = 1'b0;
      @(negedge clk);
      check("rwait_ctl", 32'({rvalid[1], arready[1]}), 32'b00);
      rst_n = 1'b0;
      #1 check("rst_arready", 32'(arready[1]), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("rst_no_rvalid", 32'(rvalid[1]), 32'd0);
      end
      rd(1, 32'h8000_0020, 3, 0);
      rd(0, 32'h8000_0010, 1, 0);

      for (int k = 0; k < 6; k++) begin
         a = 32'h8000_0200 + 32'(k * 4);
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         wr(k % 2, a, $urandom, 4'hF, (k % 2 == 1) ? 4 : 1, 0, 0);
         wr(k % 2, a, d, s, (k % 2 == 1) ? 4 : 1, 0, 0);
         rd(k % 2, a | 32'($urandom_range(0, 3)), (k % 2 == 1) ? 3 : 1, 0);
      end

      repeat (3) @(negedge clk);
      check("rq_left", rq.size(), 0);
      check("bq_left", bq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
